seg_scan_sched: RTL
===================

// Module: seg_scan_sched
// PURPOSE
//  Time-multiplexed scan controller and source arbiter for the shared 6-digit 7-segment display.
//  Two requesters share the display:
//   - normal source (lock status / elapsed timer), shown by default.
//  - alert source (error / unlock banner), pre-empts the normal source for a fixed hold time.
//  Frame content is swapped only at frame boundaries, so a digit never shows mixed sources (no tearing).
//  Each digit is followed by a blanking gap to prevent ghosting.
// PARAMETERS
//  DIGIT_CYC  50_000       clk cycles a digit is driven (1 ms @ 50 MHz)
//  BLANK_CYC  500          clk cycles all digits are off between digits (dead time); >=1
//  HOLD_CYC   100_000_000  clk cycles an alert owns the display (2 s @ 50 MHz); >=1
// PORTS
//  clk         in   1   system clock, 50 MHz
//  rstn        in   1   asynchronous active-low reset
//  norm_data   in   24  normal source, 6 hex nibbles; [3:0]=digit0 (sel[0]) ... [23:20]=digit5
//  norm_dp     in   6   normal source decimal points, 1=lit, bit i -> digit i
//  alert_req   in   1   1-cycle strobe: capture alert_data/alert_dp and start/restart hold
//  alert_data  in   24  alert source nibbles, same layout as norm_data
//  alert_dp    in   6   alert source decimal points
//  alert_busy  out  1   1 while alert source owns (or is pending for) the display
//  frame_tick  out  1   1-cycle pulse at every frame boundary
//  sel         out  6   digit enables, active-low, at most one low
//  seg         out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (async, rstn=0): sel=6'h3F, seg=8'hFF, alert_busy=0, frame_tick=0,
//   digit idx=0, scan state=BLANK, blank counter=0, frame buffer=0, dp buffer=0, hold counter=0.
//  Scan FSM (2 states):
//   BLANK: sel=6'h3F, seg=8'hFF for BLANK_CYC cycles, then -> DRIVE.
//   DRIVE: sel=~(6'b1<<idx), seg=decode(buf nibble idx, buf dp idx) for DIGIT_CYC cycles,
//    then -> BLANK with idx=idx+1; idx wraps 5->0.
//   Frame = 6*(DIGIT_CYC+BLANK_CYC) cycles. Scan order digit0..digit5 then repeat.
//  Frame boundary (DRIVE->BLANK leaving idx=5):
//   frame_tick=1 for exactly that one cycle.
//   Frame buffer reloads from the alert shadow if alert_busy, else from norm_data/norm_dp.
//   First frame after reset shows buffer=0 (all digits "0", dp off).
//  Alert arbitration:
//   alert_req=1: shadow <= alert_data/alert_dp; hold counter <= HOLD_CYC-1; alert_busy=1 next cycle.
//   alert_req during busy: retrigger; shadow re-latched, hold counter reloaded.
//   Hold counter decrements each cycle while busy.
//   At 0 with no alert_req that cycle: alert_busy=0 next cycle.
//   alert_req on the expiry cycle wins (retrigger).
//   Latency: alert content visible from the first DRIVE of the next frame (<= 1 frame after busy rises).
//   Normal content returns at the first frame boundary after busy falls.
//  Normal source is sampled only at frame boundaries; changes between boundaries are not seen until the next boundary.
//  Decoder, active-low gfedcba, combinational on the registered buffer, registered into seg:
//   0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
//   seg[7]=~dp bit.
//  sel and seg are registered and change on the same clk edge as the scan state.
//   No cycle ever has two sel bits low.
//  Counters sized $clog2 of their parameter; no other arithmetic. All logic single clock domain.
// TESTING (bench params DIGIT_CYC=4, BLANK_CYC=2, HOLD_CYC=60)
//  1. Reset: hold rstn=0 -> sel=3F, seg=FF, alert_busy=0, frame_tick=0.
//     Release -> 2 cycles blank, then sel=3E for 4 cycles.
//  2. Scan order: run 2 frames -> sel sequence 3E,3D,3B,37,2F,1F, each 4 cycles, separated by 2 cycles of 3F.
//     frame_tick every 36 cycles.
//  3. Decode: norm_data=24'h0123AF, norm_dp=6'b000001 -> next frame digit0..5 segs = 0E(F+dp),88,B0,A4,F9,C0.
//  4. Alert pre-empt: alert_req mid-frame with alert_data=24'hE88888 -> alert_busy=1 next cycle.
//     Current frame still normal; next frame shows alert.
//     Normal content returns at the first boundary after cycle 60.
//  5. Retrigger: second alert_req at hold cycle 50 with new data -> busy stays 1 for 60 more cycles.
//     New data shown from the next frame.
//  6. Reset mid-DRIVE of digit3 with alert busy -> same cycle sel=3F, seg=FF, alert_busy=0.
//     After release, scan restarts at digit0 with buffer=0.

Source files
------------

// File: rtl/seg_scan_sched.sv
// Scan controller for the shared 6-digit 7-segment display: blank/drive digit scanning,
// tear-free frame buffering, and alert-over-normal source arbitration with a hold timer.
module seg_scan_sched #(
    parameter int DIGIT_CYC = 50_000,
    parameter int BLANK_CYC = 500,
    parameter int HOLD_CYC  = 100_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] norm_data,
    input  logic [5:0]  norm_dp,
    input  logic        alert_req,
    input  logic [23:0] alert_data,
    input  logic [5:0]  alert_dp,
    output logic        alert_busy,
    output logic        frame_tick,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int CNT_MAX = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]        idx, idx_nxt;
    logic              boundary;
    logic [23:0]       buf_data, shadow_data;
    logic [5:0]        buf_dp, shadow_dp;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        digit_nib;
    logic              digit_dp;
    logic [31:0]       buf_data_ext;
    logic [7:0]        buf_dp_ext;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        boundary  = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                if (cnt == CNT_W'(DIGIT_CYC - 1)) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    if (idx == 3'd5) begin
                        idx_nxt  = 3'd0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
        endcase
    end

    // Padded views so a 3-bit digit index always selects inside the vector
    always_comb begin
        buf_data_ext = {8'h00, buf_data};
        buf_dp_ext   = {2'b00, buf_dp};
        digit_nib    = buf_data_ext[{idx_nxt, 2'b00} +: 4];
        digit_dp     = buf_dp_ext[idx_nxt];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Outputs are registered from the next scan state so they move on the same edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel        <= 6'h3F;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
            buf_data   <= '0;
            buf_dp     <= '0;
        end else begin
            frame_tick <= boundary;
            if (boundary) begin
                buf_data <= alert_busy ? shadow_data : norm_data;
                buf_dp   <= alert_busy ? shadow_dp   : norm_dp;
            end
            if (state_nxt == DRIVE) begin
                sel <= ~(6'b000001 << idx_nxt);
                seg <= {~digit_dp, decode(digit_nib)};
            end else begin
                sel <= 6'h3F;
                seg <= 8'hFF;
            end
        end
    end

    // A request always wins, including on the cycle the hold would expire
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            hold_cnt    <= '0;
            alert_busy  <= 1'b0;
        end else if (alert_req) begin
            shadow_data <= alert_data;
            shadow_dp   <= alert_dp;
            hold_cnt    <= HOLD_W'(HOLD_CYC - 1);
            alert_busy  <= 1'b1;
        end else if (alert_busy) begin
            if (hold_cnt == '0) begin
                alert_busy <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule
